// File: rtl/bram_pkg.sv
// rtl/bram_pkg.sv - shared constants, clear FSM encoding and clogb2 for bram_sdp_clr
package bram_pkg;

  localparam string PERF_HIGH  = "HIGH_PERFORMANCE";
  localparam string PERF_LOW   = "LOW_LATENCY";
  localparam string COLL_READ  = "READ_FIRST";
  localparam string COLL_WRITE = "WRITE_FIRST";

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_CLEAR = 1'b1
  } clr_state_e;

  // Number of bits needed to hold the value depth (0 for depth 0).
  function automatic int clogb2(input int depth);
    int d;
    int r;
    d = depth;
    r = 0;
    while (d > 0) begin
      r = r + 1;
      d = d >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bram_clr_fsm.sv
// rtl/bram_clr_fsm.sv - whole-array clear sequencer: walks addresses 0..RAM_DEPTH-1, one per cycle
module bram_clr_fsm
  import bram_pkg::*;
#(
  parameter int RAM_DEPTH      = 1024,
  parameter int CLEAR_ON_RESET = 1,
  parameter int ADDR_W         = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              busy,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              boot_q;  // high only until the first edge after reset release

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLR_IDLE;
      cnt_q   <= '0;
      boot_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      boot_q  <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CLR_IDLE: begin
        cnt_d = '0;
        if (clr_req || (boot_q && (CLEAR_ON_RESET != 0))) state_d = CLR_CLEAR;
      end
      CLR_CLEAR: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = CLR_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = CLR_IDLE;
    endcase
  end

  assign busy     = (state_q == CLR_CLEAR);
  assign clr_addr = cnt_q;

endmodule

// File: rtl/bram_sdp_clr.sv
// rtl/bram_sdp_clr.sv - simple dual-port block RAM with byte-column writes, read pipeline and bulk clear
module bram_sdp_clr
  import bram_pkg::*;
#(
  parameter int    RAM_WIDTH       = 18,
  parameter int    RAM_DEPTH       = 1024,
  parameter int    NB_COL          = 2,
  parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE",
  parameter string COLLISION       = "READ_FIRST",
  parameter int    CLEAR_ON_RESET  = 1,
  parameter string INIT_FILE       = "",
  localparam int   ADDR_W          = clogb2(RAM_DEPTH - 1),
  localparam int   COL_W           = RAM_WIDTH / NB_COL
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NB_COL-1:0]    wea,
  input  logic [ADDR_W-1:0]    addra,
  input  logic [RAM_WIDTH-1:0] dina,
  input  logic                 enb,
  input  logic                 regceb,
  input  logic [ADDR_W-1:0]    addrb,
  input  logic                 clr_req,
  output logic                 busy,
  output logic [RAM_WIDTH-1:0] doutb,
  output logic                 doutb_valid
);

  if ((RAM_PERFORMANCE != PERF_HIGH) && (RAM_PERFORMANCE != PERF_LOW)) begin : g_bad_perf
    $error("bram_sdp_clr: unknown RAM_PERFORMANCE");
  end
  if ((COLLISION != COLL_READ) && (COLLISION != COLL_WRITE)) begin : g_bad_coll
    $error("bram_sdp_clr: unknown COLLISION");
  end
  if ((RAM_WIDTH % NB_COL) != 0) begin : g_bad_cols
    $error("bram_sdp_clr: RAM_WIDTH must be a multiple of NB_COL");
  end
  if (INIT_FILE != "") begin : g_bad_init
    $error("bram_sdp_clr: file preload unavailable, leave INIT_FILE empty");
  end

  logic              clr_busy;
  logic [ADDR_W-1:0] clr_addr;

  bram_clr_fsm #(
    .RAM_DEPTH      (RAM_DEPTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET),
    .ADDR_W         (ADDR_W)
  ) u_clr_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .busy     (clr_busy),
    .clr_addr (clr_addr)
  );

  assign busy = clr_busy;

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] rd_word;
  logic                 collide;

  // The clear owns the write port while busy; port-A writes are dropped.
  always_ff @(posedge clk) begin
    if (clr_busy) begin
      mem[clr_addr] <= '0;
    end else begin
      for (int c = 0; c < NB_COL; c++) begin
        if (wea[c]) mem[addra][c*COL_W +: COL_W] <= dina[c*COL_W +: COL_W];
      end
    end
  end

  assign collide = !clr_busy && (addra == addrb) && (|wea);

  always_comb begin
    rd_word = mem[addrb];
    if ((COLLISION == COLL_WRITE) && collide) begin
      for (int c = 0; c < NB_COL; c++) begin
        if (wea[c]) rd_word[c*COL_W +: COL_W] = dina[c*COL_W +: COL_W];
      end
    end
  end

  logic [RAM_WIDTH-1:0] dout_q;
  logic                 dout_valid_q;

  if (RAM_PERFORMANCE == PERF_HIGH) begin : g_high
    logic [RAM_WIDTH-1:0] s1_data_q;
    logic                 s1_valid_q;

    // Stage-1 valid is consumed when the output register takes it, so one read yields one valid beat.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_data_q    <= '0;
        s1_valid_q   <= 1'b0;
        dout_q       <= '0;
        dout_valid_q <= 1'b0;
      end else begin
        if (enb) begin
          s1_data_q  <= rd_word;
          s1_valid_q <= 1'b1;
        end else if (regceb) begin
          s1_valid_q <= 1'b0;
        end
        if (regceb) begin
          dout_q       <= s1_data_q;
          dout_valid_q <= s1_valid_q;
        end
      end
    end
  end else begin : g_low
    logic unused_regceb;
    assign unused_regceb = regceb;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_q       <= '0;
        dout_valid_q <= 1'b0;
      end else begin
        if (enb) dout_q <= rd_word;
        dout_valid_q <= enb;
      end
    end
  end

  assign doutb       = dout_q;
  assign doutb_valid = dout_valid_q;

endmodule

// File: tb/tb_bram_sdp_clr.sv
// tb/tb_bram_sdp_clr.sv - directed bench: HIGH_PERF/READ_FIRST depth 1024 and LOW_LATENCY/WRITE_FIRST depth 16
module tb_bram_sdp_clr;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [1:0]  wea;
  logic [9:0]  addra, addrb;
  logic [17:0] dina, doutb;
  logic        enb, regceb, clr_req, busy, doutb_valid;

  logic [1:0]  wea_b;
  logic [3:0]  addra_b, addrb_b;
  logic [17:0] dina_b, doutb_b;
  logic        enb_b, regceb_b, clr_req_b, busy_b, doutb_valid_b;

  bram_sdp_clr u_dut_a (
    .clk (clk), .rst_n (rst_n), .wea (wea), .addra (addra), .dina (dina),
    .enb (enb), .regceb (regceb), .addrb (addrb), .clr_req (clr_req),
    .busy (busy), .doutb (doutb), .doutb_valid (doutb_valid)
  );

  bram_sdp_clr #(
    .RAM_DEPTH (16), .RAM_PERFORMANCE ("LOW_LATENCY"), .COLLISION ("WRITE_FIRST")
  ) u_dut_b (
    .clk (clk), .rst_n (rst_n), .wea (wea_b), .addra (addra_b), .dina (dina_b),
    .enb (enb_b), .regceb (regceb_b), .addrb (addrb_b), .clr_req (clr_req_b),
    .busy (busy_b), .doutb (doutb_b), .doutb_valid (doutb_valid_b)
  );

  int n_pass   = 0;
  int n_checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_a(input logic [9:0] a, input logic [17:0] d, input logic [1:0] w);
    wea = w; addra = a; dina = d;
    tick();
    wea = 2'b00;
  endtask

  task automatic read_a(input logic [9:0] a, output logic [17:0] d, output logic v);
    enb = 1'b1; addrb = a; regceb = 1'b1;
    tick();
    enb = 1'b0;
    tick();
    d = doutb; v = doutb_valid;
  endtask

  task automatic write_b(input logic [3:0] a, input logic [17:0] d, input logic [1:0] w);
    wea_b = w; addra_b = a; dina_b = d;
    tick();
    wea_b = 2'b00;
  endtask

  task automatic count_busy_a(output int cycles);
    cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (!busy) break;
      cycles++;
    end
  endtask

  task automatic count_busy_b(output int cycles);
    cycles = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (!busy_b) break;
      cycles++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          cyc;
  logic [17:0] rd;
  logic        rv;
  logic [9:0]  probe [3];

  initial begin
    rst_n = 1'b0;
    wea = '0; addra = '0; dina = '0; enb = 1'b0; regceb = 1'b0; addrb = '0; clr_req = 1'b0;
    wea_b = '0; addra_b = '0; dina_b = '0; enb_b = 1'b0; regceb_b = 1'b0; addrb_b = '0; clr_req_b = 1'b0;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 'h0);
    check("rst_doutb", 32'(doutb), 'h0);
    check("rst_valid", 32'(doutb_valid), 'h0);

    rst_n = 1'b1;
    count_busy_a(cyc);
    check("por_busy_cycles", 32'(cyc), 'd1024);
    check("por_busy_b_done", 32'(busy_b), 'h0);

    probe[0] = 10'd0; probe[1] = 10'd511; probe[2] = 10'd1023;
    for (int i = 0; i < 3; i++) begin
      read_a(probe[i], rd, rv);
      check("por_read_data", 32'(rd), 'h0);
      check("por_read_valid", 32'(rv), 'h1);
    end

    write_a(10'd5, 18'h00000, 2'b11);
    write_a(10'd5, 18'h3FFFF, 2'b01);
    enb = 1'b1; addrb = 10'd5; regceb = 1'b1;
    tick();
    enb = 1'b0;
    check("hp_valid_after_1", 32'(doutb_valid), 'h0);
    tick();
    check("col0_write_data", 32'(doutb), 'h001FF);
    check("hp_valid_after_2", 32'(doutb_valid), 'h1);

    write_a(10'd6, 18'h3FFFF, 2'b10);
    read_a(10'd6, rd, rv);
    check("col1_write_data", 32'(rd), 'h3FE00);

    tick();
    check("hp_valid_drop", 32'(doutb_valid), 'h0);
    regceb = 1'b0; enb = 1'b1; addrb = 10'd5;
    tick();
    enb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("regce_hold_data", 32'(doutb), 'h3FE00);
      check("regce_hold_valid", 32'(doutb_valid), 'h0);
    end
    regceb = 1'b1;
    tick();
    check("regce_release_data", 32'(doutb), 'h001FF);
    check("regce_release_valid", 32'(doutb_valid), 'h1);

    write_a(10'd7, 18'h00011, 2'b11);
    wea = 2'b11; addra = 10'd7; dina = 18'h00022; enb = 1'b1; addrb = 10'd7; regceb = 1'b1;
    tick();
    wea = 2'b00; enb = 1'b0;
    tick();
    check("read_first_collision", 32'(doutb), 'h00011);
    read_a(10'd7, rd, rv);
    check("read_first_after", 32'(rd), 'h00022);

    write_b(4'd7, 18'h00011, 2'b11);
    wea_b = 2'b11; addra_b = 4'd7; dina_b = 18'h00022; enb_b = 1'b1; addrb_b = 4'd7;
    tick();
    wea_b = 2'b00; enb_b = 1'b0;
    check("write_first_collision", 32'(doutb_b), 'h00022);
    check("ll_valid", 32'(doutb_valid_b), 'h1);
    tick();
    check("ll_valid_drop", 32'(doutb_valid_b), 'h0);
    check("ll_hold_data", 32'(doutb_b), 'h00022);
    wea_b = 2'b01; addra_b = 4'd7; dina_b = 18'h3FF33; enb_b = 1'b1;
    tick();
    wea_b = 2'b00; enb_b = 1'b0;
    check("write_first_merge", 32'(doutb_b), 'h00133);

    wea_b = 2'b11; addra_b = 4'd15; dina_b = 18'h00155; clr_req_b = 1'b1;
    tick();
    wea_b = 2'b00; clr_req_b = 1'b0;
    check("clr_req_busy_b", 32'(busy_b), 'h1);
    enb_b = 1'b1; addrb_b = 4'd15;
    tick();
    enb_b = 1'b0;
    check("clr_req_write_kept", 32'(doutb_b), 'h00155);
    count_busy_b(cyc);
    check("busy_cycles_b", 32'(cyc + 2), 'd16);
    enb_b = 1'b1; addrb_b = 4'd15;
    tick();
    enb_b = 1'b0;
    check("clear_b_last_addr", 32'(doutb_b), 'h0);

    clr_req = 1'b1;
    cyc = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      clr_req = 1'b0; wea = 2'b00;
      if (!busy) break;
      cyc++;
      if (i == 10) clr_req = 1'b1;
      if (i == 20) begin wea = 2'b11; addra = 10'd1023; dina = 18'h12345; end
      if (i == 600) begin wea = 2'b11; addra = 10'd0; dina = 18'h12345; end
    end
    check("clear_busy_cycles", 32'(cyc), 'd1024);
    read_a(10'd1023, rd, rv);
    check("drop_write_1023", 32'(rd), 'h0);
    read_a(10'd0, rd, rv);
    check("drop_write_0", 32'(rd), 'h0);
    read_a(10'd7, rd, rv);
    check("clear_addr_7", 32'(rd), 'h0);

    write_a(10'd9, 18'h2AAAA, 2'b11);
    read_a(10'd9, rd, rv);
    check("pre_reset_read", 32'(rd), 'h2AAAA);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (299) tick();
    check("mid_clear_busy", 32'(busy), 'h1);
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 'h0);
    check("async_rst_doutb", 32'(doutb), 'h0);
    check("async_rst_valid", 32'(doutb_valid), 'h0);
    tick();
    rst_n = 1'b1;
    count_busy_a(cyc);
    check("restart_busy_cycles", 32'(cyc), 'd1024);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
